// File: rtl/dr_pkg.sv
// Shared types and the dual-rail encode helper for the dual-rail word buffer.
package dr_pkg;

  typedef enum logic [1:0] {SPACER, CODE, PARTIAL, ILLEGAL} word_class_e;

  typedef enum logic {IN_CW, IN_SP} in_state_e;

  typedef enum logic [1:0] {OUT_SP, OUT_CW, OUT_WAIT} out_state_e;

  typedef struct packed {
    in_state_e  in_state;
    out_state_e out_state;
  } dr_dbg_t;

  // Returns {true_rail, false_rail} for one bit of value v against spacer level sp.
  function automatic logic [1:0] dr_encode(input logic v, input logic sp);
    return {sp ^ v, sp ^ ~v};
  endfunction

endpackage

// File: rtl/dr_word_detect.sv
// Combinational classifier: decides whether a dual-rail word is spacer, codeword,
// partial or illegal, and extracts the data value from the true rails.
module dr_word_detect
  import dr_pkg::*;
#(
  parameter int W  = 8,
  parameter bit SP = 1'b0
) (
  input  logic [W-1:0] d_1,
  input  logic [W-1:0] d_0,
  output word_class_e  cls,
  output logic [W-1:0] value
);

  logic [W-1:0] t_act;
  logic [W-1:0] f_act;

  always_comb begin
    t_act = d_1 ^ {W{SP}};
    f_act = d_0 ^ {W{SP}};
    value = t_act;
    // Illegal dominates: a single bit with both rails active poisons the word.
    if (|(t_act & f_act))       cls = ILLEGAL;
    else if (~|(t_act | f_act)) cls = SPACER;
    else if (&(t_act ^ f_act))  cls = CODE;
    else                        cls = PARTIAL;
  end

endmodule

// File: rtl/dr_word_buffer.sv
// Dual-rail word buffer: accepts dual-rail codewords, queues them in a FIFO and
// re-emits them as dual-rail words with independent input/output spacer levels.
module dr_word_buffer
  import dr_pkg::*;
#(
  parameter int W      = 8,
  parameter int DEPTH  = 4,
  parameter bit SP_IN  = 1'b0,
  parameter bit SP_OUT = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RN,
  input  logic [W-1:0]             D_1,
  input  logic [W-1:0]             D_0,
  output logic                     ACK_OUT,
  output logic [W-1:0]             Q_1,
  output logic [W-1:0]             Q_0,
  input  logic                     ACK_IN,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     ERR,
  output dr_dbg_t                  dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Handshake (both sides four-phase): a codeword is held until the partner raises
  // its acknowledge, then the sender returns to spacer and the partner drops the
  // acknowledge before the next codeword may appear.

  word_class_e   in_cls;
  logic [W-1:0]  in_val;
  in_state_e     in_state, in_next;
  out_state_e    out_state, out_next;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, empty, push, pop, err_q, err_set;
  logic          q_load_code, q_load_sp;
  logic [W-1:0]  q_1, q_0, enc_1, enc_0;

  dr_word_detect #(.W(W), .SP(SP_IN)) u_detect (
    .d_1   (D_1),
    .d_0   (D_0),
    .cls   (in_cls),
    .value (in_val)
  );

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  always_comb begin
    in_next = in_state;
    push    = 1'b0;
    err_set = 1'b0;
    if (in_cls == ILLEGAL) begin
      err_set = 1'b1;
    end else begin
      case (in_state)
        IN_CW: if (in_cls == CODE && !full) begin
          push    = 1'b1;
          in_next = IN_SP;
        end
        IN_SP: if (in_cls == SPACER) in_next = IN_CW;
        default: in_next = IN_CW;
      endcase
    end
  end

  // Empty is judged on the current level, so a word pushed this cycle is never
  // popped in the same cycle.
  always_comb begin
    out_next    = out_state;
    pop         = 1'b0;
    q_load_code = 1'b0;
    q_load_sp   = 1'b0;
    case (out_state)
      OUT_SP: if (!ACK_IN && !empty) begin
        pop         = 1'b1;
        q_load_code = 1'b1;
        out_next    = OUT_CW;
      end
      OUT_CW: if (ACK_IN) begin
        q_load_sp = 1'b1;
        out_next  = OUT_WAIT;
      end
      OUT_WAIT: if (!ACK_IN) out_next = OUT_SP;
      default: out_next = OUT_SP;
    endcase
  end

  always_comb begin
    enc_1 = '0;
    enc_0 = '0;
    for (int i = 0; i < W; i++) begin
      {enc_1[i], enc_0[i]} = dr_encode(mem[rd_ptr][i], SP_OUT);
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      in_state  <= IN_CW;
      out_state <= OUT_SP;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      err_q     <= 1'b0;
      q_1       <= {W{SP_OUT}};
      q_0       <= {W{SP_OUT}};
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (err_set) err_q <= 1'b1;
      // All W rails load on one edge, so the receiver never sees a partial word.
      if (q_load_code) begin
        q_1 <= enc_1;
        q_0 <= enc_0;
      end else if (q_load_sp) begin
        q_1 <= {W{SP_OUT}};
        q_0 <= {W{SP_OUT}};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_val;
  end

  assign ACK_OUT   = (in_state == IN_SP);
  assign Q_1       = q_1;
  assign Q_0       = q_0;
  assign LEVEL     = level;
  assign ERR       = err_q;
  assign dbg_state = '{in_state: in_state, out_state: out_state};

endmodule

// File: tb/tb_dr_word_buffer.sv
// Directed bench for dr_word_buffer (W=8, DEPTH=4, input spacer 0, output spacer 1).
module tb_dr_word_buffer;
  import dr_pkg::*;

  localparam int W = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset / signals ----------------
  logic         CLK = 1'b0;
  logic         RN = 1'b0;
  logic [W-1:0] D_1 = '0;
  logic [W-1:0] D_0 = '0;
  logic         ACK_IN = 1'b0;
  logic         ACK_OUT;
  logic [W-1:0] Q_1, Q_0;
  logic [2:0]   LEVEL;
  logic         ERR;
  dr_dbg_t      dbg_state;
  dr_dbg_t      exp_dbg;

  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  dr_word_buffer #(.W(W), .DEPTH(DEPTH), .SP_IN(1'b0), .SP_OUT(1'b1)) dut (
    .CLK       (CLK),
    .RN        (RN),
    .D_1       (D_1),
    .D_0       (D_0),
    .ACK_OUT   (ACK_OUT),
    .Q_1       (Q_1),
    .Q_0       (Q_0),
    .ACK_IN    (ACK_IN),
    .LEVEL     (LEVEL),
    .ERR       (ERR),
    .dbg_state (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One code cycle then one spacer cycle on the input side.
  task automatic send(input logic [W-1:0] v);
    D_1 = v;
    D_0 = ~v;
    step();
    D_1 = '0;
    D_0 = '0;
    step();
  endtask

  task automatic do_reset();
    RN = 1'b0;
    D_1 = '0;
    D_0 = '0;
    ACK_IN = 1'b0;
    step(2);
    RN = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    step(2);
    chk("rst_q1", 64'(Q_1), 64'hFF);
    chk("rst_q0", 64'(Q_0), 64'hFF);
    chk("rst_level", 64'(LEVEL), 64'd0);
    chk("rst_ack", 64'(ACK_OUT), 64'd0);
    chk("rst_err", 64'(ERR), 64'd0);
    exp_dbg = '{in_state: IN_CW, out_state: OUT_SP};
    chk("rst_dbg", 64'(dbg_state), 64'(exp_dbg));
    RN = 1'b1;

    // 1: single word A5, spacer conversion sp0 -> sp1
    D_1 = 8'hA5;
    D_0 = 8'h5A;
    step();
    chk("t1_ack_hi", 64'(ACK_OUT), 64'd1);
    chk("t1_level1", 64'(LEVEL), 64'd1);
    chk("t1_no_bypass", 64'(Q_1), 64'hFF);
    step();
    chk("t1_q1", 64'(Q_1), 64'h5A);
    chk("t1_q0", 64'(Q_0), 64'hA5);
    chk("t1_level0", 64'(LEVEL), 64'd0);
    D_1 = '0;
    D_0 = '0;
    step();
    chk("t1_ack_lo", 64'(ACK_OUT), 64'd0);
    ACK_IN = 1'b1;
    step();
    chk("t1_sp_q1", 64'(Q_1), 64'hFF);
    chk("t1_sp_q0", 64'(Q_0), 64'hFF);
    ACK_IN = 1'b0;
    step();
    chk("t1_idle_q1", 64'(Q_1), 64'hFF);
    exp_dbg = '{in_state: IN_CW, out_state: OUT_SP};
    chk("t1_dbg", 64'(dbg_state), 64'(exp_dbg));

    // 2: receiver stalled, fill FIFO, stall on full
    do_reset();
    send(8'h11);
    chk("t2_first_on_q", 64'(Q_1), 64'hEE);
    chk("t2_level0", 64'(LEVEL), 64'd0);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    chk("t2_level4", 64'(LEVEL), 64'd4);
    chk("t2_hold_q1", 64'(Q_1), 64'hEE);
    chk("t2_hold_q0", 64'(Q_0), 64'h11);
    D_1 = 8'h66;
    D_0 = 8'h99;
    step();
    chk("t2_stall_ack", 64'(ACK_OUT), 64'd0);
    chk("t2_stall_level", 64'(LEVEL), 64'd4);
    step();
    chk("t2_stall_ack2", 64'(ACK_OUT), 64'd0);
    ACK_IN = 1'b1;
    step();
    chk("t2_rx_sp", 64'(Q_1), 64'hFF);
    ACK_IN = 1'b0;
    step();
    chk("t2_wait_level", 64'(LEVEL), 64'd4);
    step();
    chk("t2_pop_level", 64'(LEVEL), 64'd3);
    chk("t2_pop_q1", 64'(Q_1), 64'hDD);
    chk("t2_pop_ack", 64'(ACK_OUT), 64'd0);
    step();
    chk("t2_push_level", 64'(LEVEL), 64'd4);
    chk("t2_push_ack", 64'(ACK_OUT), 64'd1);

    // 3: code held for 6 cycles -> one push
    do_reset();
    ACK_IN = 1'b1;
    D_1 = 8'h3C;
    D_0 = 8'hC3;
    step(6);
    chk("t3_level", 64'(LEVEL), 64'd1);
    chk("t3_ack", 64'(ACK_OUT), 64'd1);
    chk("t3_q1", 64'(Q_1), 64'hFF);
    D_1 = '0;
    D_0 = '0;
    step();
    chk("t3_ack_lo", 64'(ACK_OUT), 64'd0);
    chk("t3_level_hold", 64'(LEVEL), 64'd1);

    // 4: illegal bit 2, sticky error, FSMs keep working
    D_1 = 8'h04;
    D_0 = 8'h04;
    step();
    chk("t4_err", 64'(ERR), 64'd1);
    chk("t4_level", 64'(LEVEL), 64'd1);
    chk("t4_ack", 64'(ACK_OUT), 64'd0);
    D_1 = '0;
    D_0 = '0;
    step();
    chk("t4_err_sticky", 64'(ERR), 64'd1);
    send(8'h81);
    chk("t4_level2", 64'(LEVEL), 64'd2);
    chk("t4_err_still", 64'(ERR), 64'd1);
    // Push and pop on the same edge
    D_1 = 8'h42;
    D_0 = 8'hBD;
    ACK_IN = 1'b0;
    step();
    chk("t4_pp_level", 64'(LEVEL), 64'd2);
    chk("t4_pp_q1", 64'(Q_1), 64'hC3);
    chk("t4_pp_q0", 64'(Q_0), 64'h3C);
    chk("t4_pp_ack", 64'(ACK_OUT), 64'd1);

    // 5: partial word then completion
    do_reset();
    ACK_IN = 1'b1;
    D_1 = 8'h05;
    D_0 = 8'h0A;
    step();
    chk("t5_part_level_a", 64'(LEVEL), 64'd0);
    step(2);
    chk("t5_part_level", 64'(LEVEL), 64'd0);
    chk("t5_part_ack", 64'(ACK_OUT), 64'd0);
    D_1 = 8'h65;
    D_0 = 8'h9A;
    step();
    chk("t5_code_level", 64'(LEVEL), 64'd1);
    chk("t5_code_ack", 64'(ACK_OUT), 64'd1);
    ACK_IN = 1'b0;
    step();
    chk("t5_q1", 64'(Q_1), 64'h9A);
    chk("t5_q0", 64'(Q_0), 64'h65);
    chk("t5_level0", 64'(LEVEL), 64'd0);

    // 6: asynchronous reset during OUT_CW with LEVEL=3
    do_reset();
    D_1 = 8'h10;
    D_0 = 8'h10;
    step();
    D_1 = '0;
    D_0 = '0;
    step();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    D_1 = 8'h44;
    D_0 = 8'hBB;
    step();
    chk("t6_pre_level", 64'(LEVEL), 64'd3);
    chk("t6_pre_err", 64'(ERR), 64'd1);
    chk("t6_pre_ack", 64'(ACK_OUT), 64'd1);
    chk("t6_pre_q1", 64'(Q_1), 64'hEE);
    #2;
    RN = 1'b0;
    #1;
    chk("t6_async_q1", 64'(Q_1), 64'hFF);
    chk("t6_async_q0", 64'(Q_0), 64'hFF);
    chk("t6_async_level", 64'(LEVEL), 64'd0);
    chk("t6_async_ack", 64'(ACK_OUT), 64'd0);
    chk("t6_async_err", 64'(ERR), 64'd0);
    D_1 = '0;
    D_0 = '0;
    step();
    RN = 1'b1;
    step(2);
    chk("t6_post_level", 64'(LEVEL), 64'd0);
    chk("t6_post_q1", 64'(Q_1), 64'hFF);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
